my_alu: RTL and testbench



---
 rtl/my_alu_if.sv | 31 +++
 rtl/my_alu.sv | 102 ++++++++++
 tb/tb_my_alu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/my_alu_if.sv
// Operand/result bundle for my_alu; Cout/Ovf exist only when MY_ALU_FLAGS_EN is defined.
// master drives the operands and opcode, slave (the ALU) returns the registered result and flags.
interface my_alu_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic             inC;
   logic [2:0]       opc;
   logic [WIDTH-1:0] outW;
   logic             Zer;
   logic             Neg;
`ifdef MY_ALU_FLAGS_EN
   logic             Cout;
   logic             Ovf;
`endif

   modport master (
      output inA, inB, inC, opc,
      input  outW, Zer, Neg
`ifdef MY_ALU_FLAGS_EN
      , input Cout, Ovf
`endif
   );

   modport slave (
      input  inA, inB, inC, opc,
      output outW, Zer, Neg
`ifdef MY_ALU_FLAGS_EN
      , output Cout, Ovf
`endif
   );
endinterface

// File: rtl/my_alu.sv
// Registered ALU: 8 ops on A/B/C, result plus Zero/Negative flags one clock later.
// Optional MY_ALU_FLAGS_EN adds registered carry/borrow (Cout) and signed overflow (Ovf).
module my_alu #(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst,
   my_alu_if.slave  bus
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;
   localparam int         MSB    = WIDTH - 1;

   // The adder gets one extra bit only when its carry/borrow out is actually observed.
`ifdef MY_ALU_FLAGS_EN
   localparam int EXT = 1;
`else
   localparam int EXT = 0;
`endif

   logic [WIDTH-1+EXT:0] sum;
   logic [WIDTH-1+EXT:0] diff;
   logic [WIDTH-1:0]     res;

   assign sum  = (WIDTH+EXT)'(bus.inA) + (WIDTH+EXT)'(bus.inB) + (WIDTH+EXT)'(bus.inC);
   assign diff = (WIDTH+EXT)'(bus.inA) - (WIDTH+EXT)'(bus.inB) - (WIDTH+EXT)'(bus.inC);

`ifdef MY_ALU_FLAGS_EN
   logic carry;
   logic ovf;
`endif

   always_comb begin
      res = '0;
`ifdef MY_ALU_FLAGS_EN
      carry = 1'b0;
      ovf   = 1'b0;
`endif
      case (bus.opc)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
`ifdef MY_ALU_FLAGS_EN
            carry = sum[WIDTH];
            ovf   = (bus.inA[MSB] == bus.inB[MSB]) && (res[MSB] != bus.inA[MSB]);
`endif
         end
         OP_SUB: begin
            res = diff[WIDTH-1:0];
`ifdef MY_ALU_FLAGS_EN
            // Zero-extended difference goes negative exactly when A < B + C.
            carry = diff[WIDTH];
            ovf   = (bus.inA[MSB] != bus.inB[MSB]) && (res[MSB] != bus.inA[MSB]);
`endif
         end
         OP_AND: res = bus.inA & bus.inB;
         OP_OR:  res = bus.inA | bus.inB;
         OP_XOR: res = bus.inA ^ bus.inB;
         OP_NOT: res = ~bus.inA;
         OP_SHL: begin
            res = {bus.inA[MSB-1:0], bus.inC};
`ifdef MY_ALU_FLAGS_EN
            carry = bus.inA[MSB];
`endif
         end
         OP_SHR: begin
            res = {bus.inC, bus.inA[MSB:1]};
`ifdef MY_ALU_FLAGS_EN
            carry = bus.inA[0];
`endif
         end
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.outW <= '0;
         bus.Zer  <= 1'b1;
         bus.Neg  <= 1'b0;
`ifdef MY_ALU_FLAGS_EN
         bus.Cout <= 1'b0;
         bus.Ovf  <= 1'b0;
`endif
      end else begin
         bus.outW <= res;
         bus.Zer  <= (res == '0);
         bus.Neg  <= res[MSB];
`ifdef MY_ALU_FLAGS_EN
         bus.Cout <= carry;
         bus.Ovf  <= ovf;
`endif
      end
   end

endmodule

// File: tb/tb_my_alu.sv
// Self-checking bench for my_alu: directed vector table plus randomized stream vs. an arithmetic model.
// Cout/Ovf are checked only when MY_ALU_FLAGS_EN is defined.
module tb_my_alu;

   typedef struct {
      logic        rst;
      logic [2:0]  opc;
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] expW;
      logic        expZ;
      logic        expN;
      logic        expCout;
      logic        expOvf;
   } vec_t;

   typedef struct {
      logic [15:0] w;
      logic        z;
      logic        n;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checkCount = 0;
   int   passCount  = 0;
   vec_t vecs[$];

   my_alu_if #(.WIDTH(16)) bus ();

   my_alu #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference computed with plain integer arithmetic on unsigned/signed values.
   function automatic exp_t model(input logic r, input logic [2:0] op,
                                  input logic [15:0] a, input logic [15:0] b, input logic c);
      exp_t e;
      int ia, ib, ic, sa, sb, rv, sr;
      ia = int'(a); ib = int'(b); ic = c ? 1 : 0;
      sa = (ia >= 32768) ? ia - 65536 : ia;
      sb = (ib >= 32768) ? ib - 65536 : ib;
      e.co = 1'b0; e.ov = 1'b0; rv = 0;
      case (op)
         3'd0: begin
            rv = (ia + ib + ic) % 65536;
            e.co = (ia + ib + ic) >= 65536;
            sr = sa + sb + ic;
            e.ov = (sr > 32767) || (sr < -32768);
         end
         3'd1: begin
            rv = (ia - ib - ic + 131072) % 65536;
            e.co = ia < (ib + ic);
            sr = sa - sb - ic;
            e.ov = (sr > 32767) || (sr < -32768);
         end
         3'd2: rv = int'(a & b);
         3'd3: rv = int'(a | b);
         3'd4: rv = int'(a ^ b);
         3'd5: rv = 65535 - ia;
         3'd6: begin rv = (ia * 2 + ic) % 65536; e.co = ia >= 32768; end
         default: begin rv = ia / 2 + ic * 32768; e.co = (ia % 2) == 1; end
      endcase
      if (r) begin rv = 0; e.co = 1'b0; e.ov = 1'b0; end
      e.w = rv[15:0];
      e.z = (rv == 0);
      e.n = (rv >= 32768);
      return e;
   endfunction

   task automatic applyStimulus(input logic r, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b, input logic c);
      @(negedge clk);
      rst     = r;
      bus.opc = op;
      bus.inA = a;
      bus.inB = b;
      bus.inC = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] w, input logic z,
                              input logic n, input logic co, input logic ov);
      logic ok;
      logic actCo, actOv;
`ifdef MY_ALU_FLAGS_EN
      actCo = bus.Cout;
      actOv = bus.Ovf;
`else
      actCo = co;
      actOv = ov;
`endif
      checkCount++;
      ok = (bus.outW === w) && (bus.Zer === z) && (bus.Neg === n) &&
           (actCo === co) && (actOv === ov);
      if (ok) passCount++;
      else $display("[TB] FAIL %s: got W=%h Z=%b N=%b Cout=%b Ovf=%b, expected W=%h Z=%b N=%b Cout=%b Ovf=%b",
                    name, bus.outW, bus.Zer, bus.Neg, actCo, actOv, w, z, n, co, ov);
   endtask

   initial begin
      exp_t e;
      logic r;
      logic [2:0] op;
      logic [15:0] a, b;
      logic c;

      // rst W   opc     A        B        C     W        Z     N     Cout  Ovf
      vecs.push_back('{1'b0, 3'd0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'd1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'd2, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd3, 16'hF0F0, 16'hFF00, 1'b0, 16'hFFF0, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd4, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd5, 16'hF0F0, 16'hFF00, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd5, 16'h1234, 16'hFFFF, 1'b1, 16'hEDCB, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd4, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd6, 16'h8001, 16'h5555, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'd7, 16'h8001, 16'hAAAA, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'd7, 16'h0002, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1});

      // Two reset cycles with random inputs, then the first op must land one edge after release.
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom));
         checkOutput($sformatf("reset%0d", i), 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].c);
         checkOutput($sformatf("vec%0d", i), vecs[i].expW, vecs[i].expZ, vecs[i].expN,
                     vecs[i].expCout, vecs[i].expOvf);
      end

      // Hand sequence: result of an op, then reset overriding an ADD that would be non-zero.
      applyStimulus(1'b0, 3'd3, 16'h8000, 16'h0001, 1'b0);
      checkOutput("seq_or", 16'h8001, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
      checkOutput("seq_rst", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 3'd1, 16'h0000, 16'h0000, 1'b1);
      checkOutput("seq_resume", 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);

      // Back-to-back random ops with occasional reset pulses.
      for (int i = 0; i < 200; i++) begin
         r  = ($urandom_range(0, 19) == 0);
         op = 3'($urandom_range(0, 7));
         a  = 16'($urandom);
         b  = 16'($urandom);
         c  = 1'($urandom);
         if ($urandom_range(0, 9) == 0) b = a;
         e = model(r, op, a, b, c);
         applyStimulus(r, op, a, b, c);
         checkOutput($sformatf("rnd%0d", i), e.w, e.z, e.n, e.co, e.ov);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
